lc_bank_seq: RTL and testbench



---
 rtl/lc_bank_seq.sv | 147 ++++++++++++++
 tb/tb_lc_bank_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lc_bank_seq.sv
// Make-before-break sequencer for a binary-weighted switched LC tuning bank.
// A new tuning code is accepted over valid/ready, the union of old and new
// branches is held for MAKE_CYC cycles (skipped when only branches turn off),
// then the new code is held for SETTLE_CYC cycles and a one-cycle ack is issued.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  new tuning code offered
//   req_code   requested tuning code
//   req_ready  sequencer idle and able to accept a request
//   sw_en      registered switch enables to the bank drivers
//   busy       registered, high while a transaction is in progress
//   ack        registered one-cycle pulse: new code applied and settled
//   cur_code   registered last committed code
module lc_bank_seq #(
  parameter int unsigned NBITS      = 6,
  parameter int unsigned MAKE_CYC   = 2,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [NBITS-1:0] req_code,
  output logic             req_ready,
  output logic [NBITS-1:0] sw_en,
  output logic             busy,
  output logic             ack,
  output logic [NBITS-1:0] cur_code
);

  // Timer reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] MAKE_LOAD   = CNT_W'(MAKE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAKE   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [NBITS-1:0]   nxt_q, nxt_d;
  logic [NBITS-1:0]   sw_en_d;
  logic [NBITS-1:0]   cur_code_d;
  logic               busy_d;
  logic               ack_d;
  logic               accept;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      nxt_q    <= '0;
      sw_en    <= '0;
      cur_code <= '0;
      busy     <= 1'b0;
      ack      <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      nxt_q    <= nxt_d;
      sw_en    <= sw_en_d;
      cur_code <= cur_code_d;
      busy     <= busy_d;
      ack      <= ack_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    nxt_d      = nxt_q;
    sw_en_d    = sw_en;
    cur_code_d = cur_code;
    busy_d     = busy;
    ack_d      = 1'b0;

    case (state_q)
      IDLE: begin
        sw_en_d = cur_code;
        busy_d  = 1'b0;
        if (accept) begin
          nxt_d  = req_code;
          busy_d = 1'b1;
          if (req_code == cur_code) begin
            // Nothing to switch: commit immediately.
            state_d    = DONE;
            ack_d      = 1'b1;
            cur_code_d = req_code;
            sw_en_d    = req_code;
          end else if ((req_code & ~cur_code) == '0) begin
            // Only branches turning off: no make phase needed.
            state_d = SETTLE;
            timer_d = SETTLE_LOAD;
            sw_en_d = req_code;
          end else begin
            // Close the new branches before opening the old ones.
            state_d = MAKE;
            timer_d = MAKE_LOAD;
            sw_en_d = cur_code | req_code;
          end
        end
      end

      MAKE: begin
        if (timer_q == '0) begin
          state_d = SETTLE;
          timer_d = SETTLE_LOAD;
          sw_en_d = nxt_q;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end

      SETTLE: begin
        if (timer_q == '0) begin
          state_d    = DONE;
          ack_d      = 1'b1;
          cur_code_d = nxt_q;
          sw_en_d    = nxt_q;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        sw_en_d = nxt_q;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lc_bank_seq.sv
// Self-checking bench for lc_bank_seq (NBITS=4, MAKE_CYC=2, SETTLE_CYC=4).
// Expected per-cycle outputs are queued when a request is driven and
// compared on the falling edge of each following cycle.
module tb_lc_bank_seq;

  localparam int unsigned NB = 4;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic [NB-1:0] req_code;
  logic          req_ready;
  logic [NB-1:0] sw_en;
  logic          busy;
  logic          ack;
  logic [NB-1:0] cur_code;

  lc_bank_seq #(
    .NBITS(4),
    .MAKE_CYC(2),
    .SETTLE_CYC(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_code(req_code),
    .req_ready(req_ready),
    .sw_en(sw_en),
    .busy(busy),
    .ack(ack),
    .cur_code(cur_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] sw;
    logic          bsy;
    logic          ak;
    logic          rdy;
    logic [NB-1:0] cur;
    logic [NB-1:0] keep;
  } exp_t;

  typedef struct {
    logic [NB-1:0] code;
    logic [NB-1:0] mk;
    int            mn;
    int            sn;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Queue the expected cycle-by-cycle outputs of one transaction.
  task automatic push_txn(input logic [NB-1:0] old, input logic [NB-1:0] nw,
                          input logic [NB-1:0] mk, input int mn, input int sn);
    logic [NB-1:0] kp;
    kp = old & nw;
    for (int i = 0; i < mn; i++) sb.push_back('{mk, 1'b1, 1'b0, 1'b0, old, kp});
    for (int i = 0; i < sn; i++) sb.push_back('{nw, 1'b1, 1'b0, 1'b0, old, kp});
    sb.push_back('{nw, 1'b1, 1'b1, 1'b0, nw, kp});
    sb.push_back('{nw, 1'b0, 1'b0, 1'b1, nw, kp});
  endtask

  // Compare DUT outputs against the scoreboard once per cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("sw_en",     32'(sw_en),     32'(e.sw));
      chk("busy",      32'(busy),      32'(e.bsy));
      chk("ack",       32'(ack),       32'(e.ak));
      chk("req_ready", 32'(req_ready), 32'(e.rdy));
      chk("cur_code",  32'(cur_code),  32'(e.cur));
      chk("no_break",  32'(sw_en & e.keep), 32'(e.keep));
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'(0));
    sb.delete();
  endtask

  task automatic do_req(input logic [NB-1:0] old, input vec_t v);
    @(negedge clk);
    #1;
    push_txn(old, v.code, v.mk, v.mn, v.sn);
    req_valid = 1'b1;
    req_code  = v.code;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_drain();
  endtask

  vec_t          tbl[7];
  logic [NB-1:0] old;

  initial begin
    tbl[0] = '{4'b0101, 4'b0101, 2, 4};  // 0000 -> 0101, union = new
    tbl[1] = '{4'b0011, 4'b0111, 2, 4};  // 0101 -> 0011
    tbl[2] = '{4'b1100, 4'b1111, 2, 4};  // 0011 -> 1100, disjoint codes
    tbl[3] = '{4'b0100, 4'b0000, 0, 4};  // 1100 -> 0100, turn-off only
    tbl[4] = '{4'b0100, 4'b0000, 0, 0};  // equal code, immediate ack
    tbl[5] = '{4'b1010, 4'b1110, 2, 4};  // 0100 -> 1010
    tbl[6] = '{4'b0000, 4'b0000, 0, 4};  // 1010 -> 0000, all off

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_code  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sw_en",     32'(sw_en),     32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(1));
    chk("rst_ack",       32'(ack),       32'(0));
    chk("rst_busy",      32'(busy),      32'(0));
    chk("rst_cur_code",  32'(cur_code),  32'(0));

    old = '0;
    for (int i = 0; i < 7; i++) begin
      do_req(old, tbl[i]);
      old = tbl[i].code;
    end

    // Valid held across two codes: the second is taken on the first idle cycle.
    @(negedge clk);
    #1;
    push_txn(4'b0000, 4'b0001, 4'b0001, 2, 4);
    push_txn(4'b0001, 4'b0010, 4'b0011, 2, 4);
    req_valid = 1'b1;
    req_code  = 4'b0001;
    @(posedge clk);
    #1;
    req_code = 4'b0010;
    repeat (8) @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_drain();

    // A valid pulse while busy must be ignored.
    @(negedge clk);
    #1;
    push_txn(4'b0010, 4'b1000, 4'b1010, 2, 4);
    req_valid = 1'b1;
    req_code  = 4'b1000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_code  = 4'b0111;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_drain();

    // Reset during the fourth settle cycle: outputs clear, no ack follows.
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) sb.push_back('{4'b1110, 1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000});
    for (int i = 0; i < 3; i++) sb.push_back('{4'b0110, 1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000});
    req_valid = 1'b1;
    req_code  = 4'b0110;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_drain();
    @(posedge clk);
    #2;
    chk("pre_rst_sw_en", 32'(sw_en), 32'(4'b0110));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sw_en",    32'(sw_en),     32'(0));
    chk("mid_rst_busy",     32'(busy),      32'(0));
    chk("mid_rst_cur_code", 32'(cur_code),  32'(0));
    chk("mid_rst_ready",    32'(req_ready), 32'(1));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      chk("no_ack_after_rst", 32'(ack), 32'(0));
    end
    chk("post_rst_ready",    32'(req_ready), 32'(1));
    chk("post_rst_cur_code", 32'(cur_code),  32'(0));
    chk("post_rst_sw_en",    32'(sw_en),     32'(0));

    // Normal operation resumes from the cleared code.
    do_req(4'b0000, '{4'b0011, 4'b0011, 2, 4});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
